// File: rtl/foc_pkg.sv
// Shared definitions for the FOC speed path: default speed word format,
// quadrature Gray-state type and the signed saturation helper.
package foc_pkg;

  // Speed word format consumed by the speed controller (signed Q format)
  localparam int SPEED_N = 10;
  localparam int SPEED_F = 9;

  // The four legal encoder states, listed in forward rotation order
  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_11 = 2'b11,
    QS_10 = 2'b10
  } quad_state_t;

  // Position of a Gray state along the forward sequence 00->01->11->10.
  // The modulo-4 difference of two positions gives the direction of a step.
  function automatic logic [1:0] quad_phase(input quad_state_t s);
    case (s)
      QS_00:   quad_phase = 2'd0;
      QS_01:   quad_phase = 2'd1;
      QS_11:   quad_phase = 2'd2;
      default: quad_phase = 2'd3;
    endcase
  endfunction

  // Clamp a wide signed value into the range of a w-bit signed word.
  // The caller narrows the result to w bits with a size cast.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      sat_signed = hi;
    end else if (x < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = x;
    end
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature front end: two-flop synchronizer on the encoder pins followed
// by a 4x decoder comparing the previous and current synchronized states.
// delta/illegal are combinational from registers and valid one cycle after
// the second synchronizer flop captures a new pin state.
module quad_decoder
  import foc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_a,
  input  logic              enc_b,
  output logic signed [1:0] delta,
  output logic              illegal
);

  logic [1:0]  ab_p0;
  logic [1:0]  ab_p1;
  logic        vld_p0;
  logic        vld_p1;
  quad_state_t prev_p2;
  logic        vld_p2;
  logic [1:0]  step;

  // Stage p0/p1: metastability synchronizer; vld marks real pin samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_p0  <= '0;
      ab_p1  <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      ab_p0  <= {enc_a, enc_b};
      ab_p1  <= ab_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

  // Stage p2: previous synchronized state; vld_p2 stays low through the
  // priming sample so the reset value never gets compared against the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p2 <= QS_00;
      vld_p2  <= 1'b0;
    end else begin
      prev_p2 <= quad_state_t'(ab_p1);
      vld_p2  <= vld_p1;
    end
  end

  // Direction from the phase difference; a two-step jump is ambiguous
  always_comb begin
    delta   = 2'sd0;
    illegal = 1'b0;
    step    = quad_phase(quad_state_t'(ab_p1)) - quad_phase(prev_p2);
    if (vld_p2) begin
      case (step)
        2'd1:    delta   = 2'sd1;
        2'd3:    delta   = -2'sd1;
        2'd2:    illegal = 1'b1;
        default: delta   = 2'sd0;
      endcase
    end
  end

endmodule

// File: rtl/speed_estimator.sv
// Windowed encoder speed estimator: accumulates quadrature steps over a
// fixed window of SAMPLE_CYCLES clocks and publishes the scaled, saturated
// count as a signed speed word with a one-cycle valid strobe.
module speed_estimator
  import foc_pkg::*;
#(
  parameter int N             = SPEED_N,
  parameter int F             = SPEED_F,
  parameter int SAMPLE_CYCLES = 10000,
  parameter int SHIFT         = 4,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enc_a,
  input  logic                enc_b,
  input  logic                err_clr,
  output logic signed [N-1:0] speed,
  output logic                speed_valid,
  output logic                enc_err
);

  localparam int               WIN_W    = $clog2(SAMPLE_CYCLES);
  localparam int               EXT_W    = CNT_W + SHIFT;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);

  // Reject parameter sets the datapath cannot represent
  if (SAMPLE_CYCLES < 2 || SAMPLE_CYCLES > (1 << 20) || F >= N || EXT_W > 63) begin : g_param_check
    $error("speed_estimator: unsupported parameter combination");
  end

  logic signed [1:0]       delta_p0;
  logic                    illegal_p0;
  logic signed [CNT_W-1:0] acc_p1;
  logic [WIN_W-1:0]        win_p1;
  logic                    terminal;
  logic signed [CNT_W:0]   sum_full;
  logic signed [CNT_W-1:0] sum_sat;
  logic signed [EXT_W-1:0] scaled;
  logic signed [N-1:0]     speed_nxt;

  quad_decoder u_quad_decoder (
    .clk     (clk),
    .rst_n   (rst_n),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .delta   (delta_p0),
    .illegal (illegal_p0)
  );

  // Saturating accumulate and full-precision scaling of the closing count
  always_comb begin
    terminal  = (win_p1 == WIN_LAST);
    sum_full  = (CNT_W+1)'(acc_p1) + (CNT_W+1)'(delta_p0);
    sum_sat   = CNT_W'(sat_signed(64'(sum_full), CNT_W));
    scaled    = EXT_W'(sum_sat) <<< SHIFT;
    speed_nxt = N'(sat_signed(64'(scaled), N));
  end

  // Stage p1: window counter, accumulator and published speed. The terminal
  // cycle folds its own delta into the closing window before reloading 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p1      <= '0;
      acc_p1      <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= terminal;
      if (terminal) begin
        win_p1 <= '0;
        acc_p1 <= '0;
        speed  <= speed_nxt;
      end else begin
        win_p1 <= win_p1 + WIN_W'(1);
        acc_p1 <= sum_sat;
      end
    end
  end

  // Sticky illegal-transition flag; a new illegal step outranks the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_err <= 1'b0;
    end else if (illegal_p0) begin
      enc_err <= 1'b1;
    end else if (err_clr) begin
      enc_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_speed_estimator.sv
// Bench for speed_estimator. The reference model books every encoder step
// into the window in which it must land (pin change + 3 clock edges) and
// derives the published speed as clamp(window_sum << SHIFT).
module tb_speed_estimator;

  localparam int N     = 10;
  localparam int F     = 9;
  localparam int WIN   = 100;
  localparam int SHIFT = 4;
  localparam int CNT_W = 16;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic                enc_a   = 1'b0;
  logic                enc_b   = 1'b0;
  logic                err_clr = 1'b0;
  logic signed [N-1:0] speed;
  logic                speed_valid;
  logic                enc_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // rising edges since reset release
  int pos      = 0;   // encoder phase index along 00,01,11,10
  int held     = 0;   // speed value expected between pulses
  int win_sum[int];   // net steps landing in each window

  speed_estimator #(
    .N(N), .F(F), .SAMPLE_CYCLES(WIN), .SHIFT(SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
    .speed(speed), .speed_valid(speed_valid), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  function automatic logic [1:0] gray(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int exp_speed(input int w);
    int s;
    int lim;
    s   = win_sum.exists(w) ? win_sum[w] : 0;
    lim = 1 << (CNT_W - 1);
    if (s > lim - 1) s = lim - 1;
    if (s < -lim) s = -lim;
    s   = s * (1 << SHIFT);
    lim = 1 << (N - 1);
    if (s > lim - 1) s = lim - 1;
    if (s < -lim) s = -lim;
    return s;
  endfunction

  // act: 0 hold, +1 forward step, -1 reverse step, 2 illegal double jump
  task automatic drive(input int act);
    int w;
    w = (cyc + 2) / WIN;
    if (act == 1 || act == -1) begin
      pos = (pos + 4 + act) % 4;
      win_sum[w] = (win_sum.exists(w) ? win_sum[w] : 0) + act;
    end else if (act == 2) begin
      pos = (pos + 2) % 4;
    end
    {enc_a, enc_b} = gray(pos);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pos   = 0;
    {enc_a, enc_b} = 2'b00;
    repeat (3) @(negedge clk);
    checks += 3;
    if (speed !== 0) begin failures++; $display("FAIL reset_speed: got %0d want 0", speed); end
    if (speed_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", speed_valid); end
    if (enc_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", enc_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    int c0, o, rel, pulses;
    c0 = cyc; pulses = 0;
    for (int k = 1; k <= 2 * WIN; k++) begin
      @(negedge clk);
      o = cyc % WIN; rel = (cyc - c0 - 1) / WIN;
      checks++;
      if (o == 0) begin
        pulses++;
        held = exp_speed(cyc / WIN - 1);
        if (speed_valid !== 1'b1 || speed !== held) begin
          failures++; $display("FAIL fwd_pulse: valid=%b speed=%0d want 1/%0d", speed_valid, speed, held);
        end
        if (rel == 0) begin
          checks++;
          if (speed !== 192) begin failures++; $display("FAIL fwd_12_edges: got %0d want 192", speed); end
        end
      end else if (speed_valid !== 1'b0 || speed !== held) begin
        failures++; $display("FAIL fwd_hold: valid=%b speed=%0d want 0/%0d", speed_valid, speed, held);
      end
      rel = (cyc - c0) / WIN;
      drive((rel == 0 && o >= 5 && o <= 16) ? 1 : 0);
    end
    checks++;
    if (pulses != 2) begin failures++; $display("FAIL fwd_pulse_count: got %0d want 2", pulses); end
  endtask

  task automatic test_terminal();
    int c0, o, rel, w0, s0, s1;
    c0 = cyc; w0 = c0 / WIN; s0 = 0; s1 = 0;
    for (int k = 1; k <= 2 * WIN; k++) begin
      @(negedge clk);
      o = cyc % WIN;
      checks++;
      if (o == 0) begin
        if (speed_valid !== 1'b1) begin failures++; $display("FAIL term_valid: got %b want 1", speed_valid); end
        if (cyc / WIN - 1 == w0) s0 = speed; else s1 = speed;
        held = exp_speed(cyc / WIN - 1);
      end else if (speed_valid !== 1'b0) begin
        failures++; $display("FAIL term_spurious_valid: got %b want 0 at cycle %0d", speed_valid, cyc);
      end
      rel = (cyc - c0) / WIN;
      if (rel == 0) drive(((o >= 10 && o <= 14) || o >= 97) ? 1 : 0);
      else          drive((o == 10 || o == 11) ? 1 : 0);
    end
    checks += 3;
    if (s0 !== 96) begin failures++; $display("FAIL term_closing_window: got %0d want 96", s0); end
    if (s1 !== 64) begin failures++; $display("FAIL term_next_window: got %0d want 64", s1); end
    if (s0 + s1 !== 160) begin failures++; $display("FAIL term_total: got %0d want 160", s0 + s1); end
  endtask

  task automatic test_illegal();
    int o;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      o = cyc % WIN;
      if (o == 12 || o == 9) begin
        checks++;
        if (enc_err !== 1'b0) begin failures++; $display("FAIL err_early: got %b want 0 at offset %0d", enc_err, o); end
      end
      if (o == 14 || o == 33 || o == 40) begin
        checks++;
        if (enc_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1 at offset %0d", enc_err, o); end
      end
      if (o == 51) begin
        checks++;
        if (enc_err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", enc_err); end
      end
      if (o == 0) begin
        held = exp_speed(cyc / WIN - 1);
        checks += 2;
        if (speed_valid !== 1'b1 || speed !== held) begin
          failures++; $display("FAIL err_pulse: valid=%b speed=%0d want 1/%0d", speed_valid, speed, held);
        end
        if (speed !== 16) begin failures++; $display("FAIL err_acc_unchanged: got %0d want 16", speed); end
      end
      err_clr = (o == 32 || o == 50);
      drive(o == 5 ? 1 : (o == 10 || o == 30) ? 2 : 0);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_midwindow();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (speed_valid !== 1'b0) begin failures++; $display("FAIL mid_pre_valid: got %b want 0", speed_valid); end
      drive((k >= 10 && k < 20) ? 1 : 0);
    end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (speed !== 0) begin failures++; $display("FAIL mid_async_speed: got %0d want 0", speed); end
    if (speed_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid: got %b want 0", speed_valid); end
    if (enc_err !== 1'b0) begin failures++; $display("FAIL mid_async_err: got %b want 0", enc_err); end
    win_sum.delete();
    held = 0;
    pos  = 2;
    {enc_a, enc_b} = gray(pos);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      checks++;
      if (k < WIN) begin
        if (speed_valid !== 1'b0 || enc_err !== 1'b0 || speed !== 0) begin
          failures++; $display("FAIL mid_after_release: valid=%b err=%b speed=%0d at %0d", speed_valid, enc_err, speed, k);
        end
      end else if (speed_valid !== 1'b1 || speed !== 0 || enc_err !== 1'b0) begin
        failures++; $display("FAIL mid_first_pulse: valid=%b err=%b speed=%0d want 1/0/0", speed_valid, enc_err, speed);
      end
    end
  endtask

  task automatic test_saturation();
    int c0, o, rel;
    c0 = cyc;
    for (int k = 1; k <= 2 * WIN; k++) begin
      @(negedge clk);
      o = cyc % WIN;
      if (o == 0) begin
        held = exp_speed(cyc / WIN - 1);
        rel  = (cyc - c0 - 1) / WIN;
        checks += 2;
        if (speed_valid !== 1'b1 || speed !== held) begin
          failures++; $display("FAIL sat_pulse: valid=%b speed=%0d want 1/%0d", speed_valid, speed, held);
        end
        if (speed !== (rel == 0 ? -512 : 511)) begin
          failures++; $display("FAIL sat_clamp: got %0d want %0d", speed, rel == 0 ? -512 : 511);
        end
      end
      rel = (cyc - c0) / WIN;
      drive((o >= 5 && o < 45) ? (rel == 0 ? -1 : 1) : 0);
    end
  endtask

  task automatic test_random();
    int o, r, w;
    for (int k = 1; k <= 6 * WIN; k++) begin
      @(negedge clk);
      o = cyc % WIN;
      w = cyc / WIN;
      checks++;
      if (o == 0) begin
        held = exp_speed(w - 1);
        if (speed_valid !== 1'b1 || speed !== held || enc_err !== 1'b0) begin
          failures++; $display("FAIL rand_pulse: valid=%b speed=%0d err=%b want 1/%0d/0", speed_valid, speed, enc_err, held);
        end
      end else if (speed_valid !== 1'b0 || speed !== held) begin
        failures++; $display("FAIL rand_hold: valid=%b speed=%0d want 0/%0d", speed_valid, speed, held);
      end
      r = $urandom_range(0, 9);
      if (w % 2 == 0) drive(r < 4 ? 1 : (r == 4 ? -1 : 0));
      else            drive(r < 3 ? -1 : (r == 3 ? 1 : 0));
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_terminal();
    test_illegal();
    test_reset_midwindow();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/speed_estimator.md
SPEED_ESTIMATOR -- requirements
Module: speed_estimator

Interface
REQ-001 SHALL have parameter N, default 10, speed output width in bits.
REQ-002 SHALL have parameter F, default 9, fractional bits of speed (signed Q format, same as speed controller input).
REQ-003 SHALL have parameter SAMPLE_CYCLES, default 10000, clk cycles per speed window (legal range 2..2^20).
REQ-004 SHALL have parameter SHIFT, default 4, left shift applied to the window edge count to scale it to speed LSBs.
REQ-005 SHALL have parameter CNT_W, default 16, edge accumulator width.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 enc_a  input  1  encoder channel A, asynchronous to clk.
REQ-009 enc_b  input  1  encoder channel B, asynchronous to clk.
REQ-010 err_clr  input  1  synchronous clear of enc_err.
REQ-011 speed  output  N signed  latest window speed estimate, feeds speed controller speed input.
REQ-012 speed_valid  output  1  one-cycle pulse when speed updates.
REQ-013 enc_err  output  1  sticky illegal-transition flag.

Function
REQ-014 SHALL pass enc_a/enc_b through a 2-flop synchronizer before any use.
REQ-015 SHALL decode 4x quadrature from previous vs current synchronized {a,b}: 00->01->11->10->00 = +1, reverse order = -1, no change = 0.
REQ-016 SHALL treat both bits changing in one cycle as illegal: delta 0, enc_err set.
REQ-017 SHALL suppress decoding on the first synchronized sample after reset (priming cycle), so any static encoder state yields delta 0 and no error.
REQ-018 Latency: pin edge SHALL reach the accumulator within 3 clk cycles (2 sync + 1 decode).
REQ-019 SHALL add delta to a signed CNT_W accumulator each cycle, saturating at -2^(CNT_W-1) and 2^(CNT_W-1)-1 (no wrap).
REQ-020 SHALL run a window counter 0..SAMPLE_CYCLES-1, wrapping to 0 after terminal count.
REQ-021 At terminal count SHALL register speed = saturate_N(accumulator_including_this_cycle_delta << SHIFT) and pulse speed_valid for exactly that next cycle.
REQ-022 At terminal count SHALL reload accumulator with 0; a delta occurring on the terminal cycle is counted in the closing window, none lost or double-counted.
REQ-023 Output saturation SHALL clamp to [-2^(N-1), 2^(N-1)-1] using full-precision intermediate (CNT_W+SHIFT bits).
REQ-024 speed SHALL hold its value between pulses.
REQ-025 enc_err SHALL stay 1 until err_clr; illegal transition and err_clr in the same cycle SHALL leave enc_err = 1 (set wins).

Reset
REQ-026 rst_n low SHALL immediately clear synchronizers, priming flag, accumulator, window counter, speed = 0, speed_valid = 0, enc_err = 0.
REQ-027 Reset mid-window SHALL discard partial count; first speed_valid after release occurs SAMPLE_CYCLES cycles after reset deassertion.

Structure
REQ-028 Shared package foc_pkg SHALL hold N/F defaults, quadrature state typedef (2-bit enum of the four Gray states) and the signed saturation function.
REQ-029 Quadrature synchronizer+decoder SHALL be sub-module quad_decoder (outputs delta in {-1,0,+1} and illegal strobe); windowing/scaling stays in speed_estimator.

Verification (SAMPLE_CYCLES=100, SHIFT=4, N=10 unless stated)
REQ-030 12 forward edges in one window -> speed = 192, speed_valid single pulse per 100 cycles.
REQ-031 40 reverse edges -> speed = -512 (saturated from -640); 40 forward -> 511.
REQ-032 Forced 00->11 jump -> enc_err = 1, accumulator unchanged; err_clr pulse coinciding with a second illegal jump -> enc_err stays 1; later err_clr alone -> 0.
REQ-033 Edge arriving so its delta lands on terminal cycle -> counted in closing window, next window starts from 0 (total over two windows equals edges driven).
REQ-034 Encoder held at 11 through reset, rst_n pulsed mid-window -> no enc_err, speed = 0, first speed_valid exactly 100 cycles after release.
